// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO.
// Queued words leave back-to-back; data width, parity and stop bits are parameters.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic [7:0]                    i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = AW + 1;
    localparam int STOP_CLKS = STOP_BITS * CPB;
    localparam int BW        = $clog2(STOP_CLKS);
    localparam logic ODD     = (PARITY == 2);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CPB < 2) begin : g_bad_cfg
            $error("uart_tx_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [2:0]             bit_q, bit_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic                   tx_q, tx_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic push, pop, has_word, bit_end, stop_end;

    assign o_ready      = (count_q != CW'(FIFO_DEPTH));
    assign has_word     = (count_q != '0);
    assign push         = i_valid && o_ready;
    assign bit_end      = (baud_q == BW'(CPB - 1));
    assign stop_end     = (baud_q == BW'(STOP_CLKS - 1));
    assign o_tx         = tx_q;
    assign o_busy       = (state_q != S_IDLE) || has_word;
    assign o_fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (has_word) pop = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    baud_d = '0;
                    if (has_word) pop = 1'b1;
                    else          state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Parity is latched with the word so later pushes cannot disturb it
        if (pop) begin
            shift_d = mem_q[rptr_q];
            par_d   = (^mem_q[rptr_q]) ^ ODD;
            bit_d   = '0;
            baud_d  = '0;
            state_d = S_START;
        end

        // Line is registered from next state so it changes with the state
        unique case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) mem_q[wptr_q] <= i_data[DATA_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations at 4 clocks per bit,
// frames decoded from the line and scored against a queue of pushed words.
module tb_uart_tx_fifo;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] vld   = '0;
    logic [7:0] din   = '0;
    logic [2:0] tx_w, busy_w, rdy_w;
    logic [2:0] cnt [3];
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sel 0: 8N1, sel 1: 7 bits even parity 2 stop, sel 2: 8 bits odd parity 1 stop
    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000)) u_d0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[0]), .i_data(din),
        .o_ready(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]),
        .o_fifo_count(cnt[0]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000),
                   .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[1]), .i_data(din),
        .o_ready(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]),
        .o_fifo_count(cnt[1]));

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000),
                   .PARITY(2)) u_d2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vld[2]), .i_data(din),
        .o_ready(rdy_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]),
        .o_fifo_count(cnt[2]));

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_par;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    function automatic int dbits(input int sel);
        return (sel == 1) ? 7 : 8;
    endfunction

    function automatic int pbits(input int sel);
        return (sel == 0) ? 0 : 1;
    endfunction

    function automatic int sbits(input int sel);
        return (sel == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int sel);
        return 1 + dbits(sel) + pbits(sel) + sbits(sel);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int sel, input logic [7:0] d,
                             input exp_t e, output int pc);
        @(negedge clk);
        din      = d;
        vld[sel] = 1'b1;
        if (rdy_w[sel] === 1'b1) sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        pc       = cyc;
        vld[sel] = 1'b0;
    endtask

    task automatic collect(input int sel, input int nfr,
                           output int st0, output logic [2:0] c0);
        int         prev, st, w, nb;
        logic [11:0] got;
        logic       glitch, stopok;
        logic [7:0] d;
        exp_t       e;
        nb   = flen(sel);
        prev = 0;
        st0  = 0;
        c0   = '0;
        for (int f = 0; f < nfr; f++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (tx_w[sel] !== 1'b0 && w < 400);
            if (tx_w[sel] !== 1'b0) begin
                check("start_seen", {31'd0, tx_w[sel]}, 0);
                return;
            end
            st = cyc;
            if (f == 0) begin
                st0 = st;
                c0  = cnt[sel];
            end else begin
                check("pitch", st - prev, nb * 4);
            end
            prev   = st;
            got    = '0;
            glitch = 1'b0;
            for (int i = 0; i < nb * 4; i++) begin
                if (i > 0) @(negedge clk);
                if (i % 4 == 0) got[i/4] = tx_w[sel];
                else if (tx_w[sel] !== got[i/4]) glitch = 1'b1;
            end
            d = '0;
            for (int j = 0; j < dbits(sel); j++) d[j] = got[1+j];
            stopok = 1'b1;
            for (int j = 0; j < sbits(sel); j++)
                stopok = stopok & got[1+dbits(sel)+pbits(sel)+j];
            if (sb_q.size() == 0) begin
                check("unexpected_frame", d, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("data", d, e.data);
                if (pbits(sel) != 0) check("parity", got[1+dbits(sel)], e.par);
            end
            check("stop", stopok, 1);
            check("bit_width", glitch, 0);
        end
    endtask

    task automatic wait_idle(input int sel, input int st, input int nfr);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (busy_w[sel] !== 1'b0 && w < 200);
        check("busy_fall", cyc - st, nfr * flen(sel) * 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int         pc, st, lows;
        logic [2:0] c0;
        exp_t       e;
        int         expc[5];
        logic       expr[5];

        vecs[0] = '{0, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'h3C, 8'h3C, 1'b0};
        vecs[2] = '{1, 8'h53, 8'h53, 1'b0};
        vecs[3] = '{1, 8'hFF, 8'h7F, 1'b1};
        vecs[4] = '{1, 8'h80, 8'h00, 1'b0};
        vecs[5] = '{2, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{2, 8'h81, 8'h81, 1'b1};
        vecs[7] = '{2, 8'h07, 8'h07, 1'b0};
        expc    = '{1, 1, 2, 3, 4};
        expr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        #1 rst_n = 1'b0;
        #2;
        check("rst_tx0", tx_w[0], 1);
        check("rst_busy0", busy_w[0], 0);
        check("rst_ready0", rdy_w[0], 1);
        check("rst_count0", cnt[0], 0);
        check("rst_tx1", tx_w[1], 1);
        check("rst_tx2", tx_w[2], 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            e.data = vecs[k].exp_data;
            e.par  = vecs[k].exp_par;
            push_word(vecs[k].sel, vecs[k].din, e, pc);
            check("count_after_push", cnt[vecs[k].sel], 1);
            collect(vecs[k].sel, 1, st, c0);
            check("latency", st - pc, 1);
            check("count_at_start", c0, 0);
            wait_idle(vecs[k].sel, st, 1);
        end

        fork
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    din    = 8'h11 * 8'(k + 1);
                    vld[0] = 1'b1;
                    e.data = din;
                    e.par  = 1'b0;
                    if (rdy_w[0] === 1'b1) sb_q.push_back(e);
                    @(posedge clk);
                    @(negedge clk);
                    check("burst_count", cnt[0], expc[k]);
                    check("burst_ready", rdy_w[0], expr[k]);
                end
                din = 8'h66;
                for (int j = 0; j < 3; j++) begin
                    e.data = din;
                    if (rdy_w[0] === 1'b1) sb_q.push_back(e);
                    @(posedge clk);
                    @(negedge clk);
                    check("full_hold_count", cnt[0], 4);
                end
                vld[0] = 1'b0;
            end
            begin
                collect(0, 5, st, c0);
            end
        join
        wait_idle(0, st, 5);
        check("sb_drained", sb_q.size(), 0);

        @(negedge clk);
        vld[0] = 1'b1;
        din    = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        din = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        din = 8'hBB;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("count_before_reset", cnt[0], 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx_w[0], 1);
        check("midrst_count", cnt[0], 0);
        check("midrst_busy", busy_w[0], 0);
        check("midrst_ready", rdy_w[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
        end
        check("idle_after_reset", lows, 0);

        e.data = 8'h5A;
        e.par  = 1'b0;
        push_word(0, 8'h5A, e, pc);
        collect(0, 1, st, c0);
        check("recover_latency", st - pc, 1);
        wait_idle(0, st, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
